// File: rtl/peri_serial_receiver_if.sv
// peri_serial_receiver_if: 3-wire link inputs plus valid/ready word output of the serial receiver
//   p_clock, p_data, p_cs : link from the computer core (p_cs active-low)
//   data_out, data_valid  : committed word and its valid flag
//   data_ready            : consumer handshake
//   busy, frame_err, overrun : status (frame_err/overrun are 1-cycle pulses)
//   master = link driver / consumer side, slave = receiver side
interface peri_serial_receiver_if #(parameter int WIDTH = 16);
    logic             p_clock;
    logic             p_data;
    logic             p_cs;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;
    modport master (
        output p_clock, p_data, p_cs, data_ready,
        input  data_out, data_valid, busy, frame_err, overrun
    );
    modport slave (
        input  p_clock, p_data, p_cs, data_ready,
        output data_out, data_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/peri_serial_receiver.sv
// peri_serial_receiver: synchronises a 3-wire link and deserialises one MSB-first WIDTH-bit word per p_cs frame
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : link inputs, valid/ready word output, busy/frame_err/overrun status
module peri_serial_receiver #(
    parameter int WIDTH      = 16,
    parameter int SYNC_DEPTH = 2
) (
    input logic                  clock,
    input logic                  reset,
    peri_serial_receiver_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RECV, FULL} state_t;
    state_t                state, state_n;
    logic [SYNC_DEPTH-1:0] cs_sync, ck_sync, dt_sync;
    logic                  cs_s, ck_s, cs_h, ck_h;
    logic [SYNC_DEPTH+1:0] flush;
    logic                  armed;
    logic                  ev_clk, ev_cs_fall, ev_cs_rise, ev_data;
    logic [WIDTH-1:0]      shift, shift_n, data_out;
    logic [CW-1:0]         count, count_n;
    logic                  extra, extra_n, eval, eval_n, good, good_n;
    logic                  data_valid, frame_err, overrun;

    assign cs_s = cs_sync[SYNC_DEPTH-1];
    assign ck_s = ck_sync[SYNC_DEPTH-1];

    // Synchronisers, history flops and registered edge events.
    // After reset the chains hold preset values rather than the link; flush waits until every
    // stage is link-derived, and armed then requires p_cs seen high so that a frame already in
    // progress at reset release cannot start a reception.
    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync    <= '1;
            ck_sync    <= '0;
            dt_sync    <= '0;
            cs_h       <= 1'b1;
            ck_h       <= 1'b0;
            flush      <= '0;
            armed      <= 1'b0;
            ev_clk     <= 1'b0;
            ev_cs_fall <= 1'b0;
            ev_cs_rise <= 1'b0;
            ev_data    <= 1'b0;
        end else begin
            cs_sync    <= {cs_sync[SYNC_DEPTH-2:0], bus.p_cs};
            ck_sync    <= {ck_sync[SYNC_DEPTH-2:0], bus.p_clock};
            dt_sync    <= {dt_sync[SYNC_DEPTH-2:0], bus.p_data};
            cs_h       <= cs_s;
            ck_h       <= ck_s;
            flush      <= {flush[SYNC_DEPTH:0], 1'b1};
            armed      <= armed | (flush[SYNC_DEPTH+1] & cs_h);
            ev_clk     <= ck_s & ~ck_h;
            ev_cs_fall <= armed & cs_h & ~cs_s;
            ev_cs_rise <= cs_s & ~cs_h;
            ev_data    <= dt_sync[SYNC_DEPTH-1];
        end
    end

    // Next state; a bit arriving together with p_cs rise is shifted before the frame is judged.
    always_comb begin
        state_n = state;
        shift_n = shift;
        count_n = count;
        extra_n = extra;
        eval_n  = 1'b0;
        good_n  = good;
        if (state == IDLE) begin
            if (ev_cs_fall) begin
                state_n = RECV;
                shift_n = '0;
                count_n = '0;
                extra_n = 1'b0;
            end
        end else begin
            if (ev_clk) begin
                if (state == RECV) begin
                    shift_n = {shift[WIDTH-2:0], ev_data};
                    count_n = count + CW'(1);
                    state_n = (count_n == CW'(WIDTH)) ? FULL : RECV;
                end else begin
                    extra_n = 1'b1;
                end
            end
            if (ev_cs_rise) begin
                state_n = IDLE;
                eval_n  = 1'b1;
                good_n  = (count_n == CW'(WIDTH)) & ~extra_n;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            shift <= '0;
            count <= '0;
            extra <= 1'b0;
            eval  <= 1'b0;
            good  <= 1'b0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            count <= count_n;
            extra <= extra_n;
            eval  <= eval_n;
            good  <= good_n;
        end
    end

    // Commit stage: runs the cycle after a frame is judged.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= eval & ~good;
            overrun   <= eval & good & data_valid & ~bus.data_ready;
            if (eval & good & (~data_valid | bus.data_ready)) begin
                data_out   <= shift;
                data_valid <= 1'b1;
            end else if (data_valid & bus.data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.frame_err  = frame_err;
    assign bus.overrun    = overrun;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_peri_serial_receiver.sv
// tb_peri_serial_receiver: directed self-checking bench for peri_serial_receiver (clock/p_clock ratio 8)
module tb_peri_serial_receiver;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fe_cyc = 0, ov_cyc = 0, dv_cyc = 0, dv_rise = 0;
    logic dv_q = 1'b0;
    int   fe0, ov0, dv0, dr0, lat;

    peri_serial_receiver_if #(.WIDTH(16)) bus ();

    peri_serial_receiver #(.WIDTH(16), .SYNC_DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Pulse/level activity counters sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.frame_err) fe_cyc <= fe_cyc + 1;
        if (bus.overrun) ov_cyc <= ov_cyc + 1;
        if (bus.data_valid) dv_cyc <= dv_cyc + 1;
        if (bus.data_valid & ~dv_q) dv_rise <= dv_rise + 1;
        dv_q <= bus.data_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic link_bit(input logic b);
        bus.p_data = b;
        tick(4);
        bus.p_clock = 1'b1;
        tick(4);
        bus.p_clock = 1'b0;
    endtask

    // Leaves p_cs freshly raised, #1 after a clock edge.
    task automatic send(input logic [31:0] word, input int nbits);
        bus.p_cs = 1'b0;
        tick(4);
        for (int i = nbits - 1; i >= 0; i--) link_bit(word[i]);
        tick(4);
        bus.p_cs = 1'b1;
    endtask

    task automatic snap();
        fe0 = fe_cyc;
        ov0 = ov_cyc;
        dv0 = dv_cyc;
        dr0 = dv_rise;
    endtask

    initial begin
        bus.p_clock = 1'b0;
        bus.p_data = 1'b0;
        bus.p_cs = 1'b1;
        bus.data_ready = 1'b0;
        tick(5);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        tick(1);
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        tick(10);

        bus.data_ready = 1'b1;
        snap();
        send(32'hA5C3, 16);
        tick(12);
        check("t1_data", 32'(bus.data_out), 32'hA5C3);
        check("t1_valid_cycles", 32'(dv_cyc - dv0), 32'd1);
        check("t1_frame_err", 32'(fe_cyc - fe0), 32'd0);
        check("t1_overrun", 32'(ov_cyc - ov0), 32'd0);

        snap();
        send(32'h7FFF, 15);
        tick(12);
        check("t2_frame_err", 32'(fe_cyc - fe0), 32'd1);
        check("t2_valid", 32'(dv_cyc - dv0), 32'd0);
        check("t2_data", 32'(bus.data_out), 32'hA5C3);

        snap();
        send(32'h10000, 17);
        tick(12);
        check("t3_frame_err", 32'(fe_cyc - fe0), 32'd1);
        check("t3_valid", 32'(dv_cyc - dv0), 32'd0);
        check("t3_data", 32'(bus.data_out), 32'hA5C3);

        snap();
        send(32'h0, 0);
        tick(12);
        check("zero_frame_err", 32'(fe_cyc - fe0), 32'd1);
        check("zero_valid", 32'(dv_cyc - dv0), 32'd0);

        bus.data_ready = 1'b0;
        snap();
        send(32'h1234, 16);
        tick(12);
        check("t4_data1", 32'(bus.data_out), 32'h1234);
        check("t4_valid1", 32'(bus.data_valid), 32'd1);
        send(32'h5678, 16);
        tick(12);
        check("t4_overrun", 32'(ov_cyc - ov0), 32'd1);
        check("t4_data_held", 32'(bus.data_out), 32'h1234);
        check("t4_valid_held", 32'(bus.data_valid), 32'd1);
        bus.data_ready = 1'b1;
        tick(2);
        check("t4_valid_drop", 32'(bus.data_valid), 32'd0);

        bus.data_ready = 1'b0;
        send(32'h1111, 16);
        tick(12);
        check("e_data1", 32'(bus.data_out), 32'h1111);
        snap();
        send(32'h2222, 16);
        tick(4);
        bus.data_ready = 1'b1;
        tick(1);
        bus.data_ready = 1'b0;
        check("e_data2", 32'(bus.data_out), 32'h2222);
        check("e_valid", 32'(bus.data_valid), 32'd1);
        tick(4);
        check("e_overrun", 32'(ov_cyc - ov0), 32'd0);
        bus.data_ready = 1'b1;
        tick(2);
        check("e_valid_drop", 32'(bus.data_valid), 32'd0);

        snap();
        bus.p_cs = 1'b0;
        tick(4);
        for (int i = 15; i >= 8; i--) link_bit(1'(32'hBEEF >> i));
        tick(4);
        check("t5_busy_mid", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick(2);
        check("t5_busy_rst", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        tick(2);
        bus.p_cs = 1'b1;
        tick(10);
        send(32'h0F0F, 16);
        tick(12);
        check("t5_data", 32'(bus.data_out), 32'h0F0F);
        check("t5_commits", 32'(dv_rise - dr0), 32'd1);
        check("t5_frame_err", 32'(fe_cyc - fe0), 32'd0);

        lat = -1;
        send(32'hC001, 16);
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_valid) begin
                lat = k;
                break;
            end
        end
        check("t6_latency", 32'(lat), 32'd4);
        check("t6_data", 32'(bus.data_out), 32'hC001);
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
